// File: rtl/pwm_decode.sv
// pwm_decode: measures high time and rise-to-rise period of an asynchronous
// PWM input in clk cycles. It publishes duty/period with a one-cycle valid
// strobe once per complete period and flags loss of signal.
//
// Optional build macro: PWM_DECODE_GLITCH_FILTER_EN
//   When defined, the synchronized level must hold a new value for three
//   consecutive cycles before it is accepted. Pulses of 1-2 cycles are
//   swallowed, and the strobe latency grows by two cycles.
//
// Output protocol: valid is a plain one-cycle strobe with no back-pressure.
// duty/period change only in the cycle valid is high and hold otherwise.
`timescale 1ns/1ps

module pwm_decode #(
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [10:0] duty,
  output logic [11:0] period,
  output logic        valid,
  output logic        no_sig
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);
  localparam logic [10:0] HI_MAX    = 11'h7FF;
  localparam logic [11:0] PER_MAX   = 12'hFFF;

  state_t      state_q;
  state_t      state_d;

  logic        s1;
  logic        s2;
  logic        s3;
  logic        lvl;
  logic        rise;
  logic        fall;

  logic [10:0] hi_cnt;
  logic [10:0] hi_lat;
  logic [11:0] per_cnt;
  logic [12:0] per_plus;
  logic [11:0] per_sat;
  logic        timeout_hit;

  logic        arm;
  logic        latch_hi;
  logic        publish;
  logic        expire;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_DECODE_GLITCH_FILTER_EN
  logic h1;
  logic h2;

  // History of the synchronized level, used to qualify level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= 1'b0;
      h2 <= 1'b0;
    end else begin
      h1 <= s2;
      h2 <= h1;
    end
  end

  // Accept a new level only when three consecutive samples agree; otherwise keep the last accepted level.
  always_comb begin
    lvl = s3;
    if ((s2 == h1) && (h1 == h2)) begin
      lvl = s2;
    end
  end
`else
  // Without the filter, every synchronized level change is an edge.
  always_comb begin
    lvl = s2;
  end
`endif

  // Edge register: remembers the previous conditioned level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3 <= 1'b0;
    end else begin
      s3 <= lvl;
    end
  end

  assign rise        = lvl & ~s3;
  assign fall        = ~lvl & s3;
  assign timeout_hit = (per_cnt == TIMEOUT_C);
  assign per_plus    = {1'b0, per_cnt} + 13'd1;
  assign per_sat     = per_plus[12] ? PER_MAX : per_plus[11:0];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath controls. A rise always beats a timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    arm      = 1'b0;
    latch_hi = 1'b0;
    publish  = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          arm     = 1'b1;
        end
      end
      HIGH: begin
        if (rise) begin
          arm = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
          expire  = 1'b1;
        end else if (fall) begin
          state_d  = LOW;
          latch_hi = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          arm     = 1'b1;
          publish = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
          expire  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // High-time and period counters, both restarted by every accepted rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt  <= 11'd0;
      per_cnt <= 12'd0;
    end else begin
      if (arm) begin
        hi_cnt <= 11'd1;
      end else if ((state_q == HIGH) && !fall && (hi_cnt != HI_MAX)) begin
        hi_cnt <= hi_cnt + 11'd1;
      end
      if (arm) begin
        per_cnt <= 12'd0;
      end else if ((state_q != IDLE) && (per_cnt != PER_MAX)) begin
        per_cnt <= per_cnt + 12'd1;
      end
    end
  end

  // Latched high time of the current period; forgotten when the input dies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_lat <= 11'd0;
    end else if (latch_hi) begin
      hi_lat <= hi_cnt;
    end else if (expire) begin
      hi_lat <= 11'd0;
    end
  end

  // Published results, strobe and loss-of-signal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty   <= 11'd0;
      period <= 12'd0;
      valid  <= 1'b0;
      no_sig <= 1'b1;
    end else begin
      valid <= publish;
      if (publish) begin
        duty   <= hi_lat;
        period <= per_sat;
        no_sig <= 1'b0;
      end else if (expire) begin
        no_sig <= 1'b1;
      end
    end
  end

endmodule
